// File: rtl/wb_regfile.sv
// Writeback select, 32x32 architectural register file with x0 hardwired to zero,
// same-cycle write bypass on both read ports, retire counter and commit trace.
module wb_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       mem_wb_rd,
    input  logic             mem_wb_mem_to_reg,
    input  logic             mem_wb_regwrite,
    input  logic             mem_wb_ins_valid,
    input  logic [XLEN-1:0]  mem_wb_aluout1,
    input  logic [XLEN-1:0]  mem_wb_aluout2,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             wb_commit_valid,
    output logic             wb_commit_we,
    output logic [4:0]       wb_commit_rd,
    output logic [XLEN-1:0]  wb_commit_data,
    output logic [CNT_W-1:0] instret
);

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] wb_data;
    logic            wb_we;

    // Writeback value select and effective write enable (bubbles and x0 never write)
    always_comb begin
        wb_data = mem_wb_mem_to_reg ? mem_wb_aluout2 : mem_wb_aluout1;
        wb_we   = mem_wb_ins_valid && mem_wb_regwrite && (mem_wb_rd != 5'd0);
    end

    // Read ports: x0 reads zero, in-flight write is bypassed, everything is zero in reset
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rst) begin
            if (id_rs1 != 5'd0) begin
                rs1_data = (wb_we && (id_rs1 == mem_wb_rd)) ? wb_data : regs[id_rs1];
            end
            if (id_rs2 != 5'd0) begin
                rs2_data = (wb_we && (id_rs2 == mem_wb_rd)) ? wb_data : regs[id_rs2];
            end
        end
    end

    // Register array; entry 0 exists but is never written or read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[mem_wb_rd] <= wb_data;
        end
    end

    // Retire counter and commit trace
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret         <= '0;
            wb_commit_valid <= 1'b0;
            wb_commit_we    <= 1'b0;
            wb_commit_rd    <= '0;
            wb_commit_data  <= '0;
        end else begin
            if (mem_wb_ins_valid) begin
                instret <= instret + CNT_W'(1);
            end
            wb_commit_valid <= mem_wb_ins_valid;
            wb_commit_we    <= wb_we;
            wb_commit_rd    <= wb_we ? mem_wb_rd : 5'd0;
            wb_commit_data  <= wb_we ? wb_data : '0;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, bypass, load select, x0, bubbles,
// back-to-back writes, mid-stream reset and counter wrap (narrow-counter instance).
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_mem_to_reg;
    logic        mem_wb_regwrite;
    logic        mem_wb_ins_valid;
    logic [31:0] mem_wb_aluout1;
    logic [31:0] mem_wb_aluout2;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_commit_valid, wb_commit_we;
    logic [4:0]  wb_commit_rd;
    logic [31:0] wb_commit_data;
    logic [63:0] instret;

    logic [31:0] n_rs1_data, n_rs2_data;
    logic        n_commit_valid, n_commit_we;
    logic [4:0]  n_commit_rd;
    logic [31:0] n_commit_data;
    logic [1:0]  n_instret;

    int n_checks = 0;
    int n_pass   = 0;

    wb_regfile dut (
        .clk(clk), .rst(rst),
        .mem_wb_rd(mem_wb_rd), .mem_wb_mem_to_reg(mem_wb_mem_to_reg),
        .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_ins_valid(mem_wb_ins_valid),
        .mem_wb_aluout1(mem_wb_aluout1), .mem_wb_aluout2(mem_wb_aluout2),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_commit_valid(wb_commit_valid), .wb_commit_we(wb_commit_we),
        .wb_commit_rd(wb_commit_rd), .wb_commit_data(wb_commit_data),
        .instret(instret)
    );

    // Same stimulus, 2-bit counter so the wrap is reachable in a few cycles
    wb_regfile #(.CNT_W(2)) dut_narrow (
        .clk(clk), .rst(rst),
        .mem_wb_rd(mem_wb_rd), .mem_wb_mem_to_reg(mem_wb_mem_to_reg),
        .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_ins_valid(mem_wb_ins_valid),
        .mem_wb_aluout1(mem_wb_aluout1), .mem_wb_aluout2(mem_wb_aluout2),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
        .wb_commit_valid(n_commit_valid), .wb_commit_we(n_commit_we),
        .wb_commit_rd(n_commit_rd), .wb_commit_data(n_commit_data),
        .instret(n_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Set up the WB slot and read addresses just after a falling edge
    task automatic drive(input logic [4:0] rd, input logic m2r, input logic rw, input logic v,
                         input logic [31:0] a1, input logic [31:0] a2,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        mem_wb_rd         = rd;
        mem_wb_mem_to_reg = m2r;
        mem_wb_regwrite   = rw;
        mem_wb_ins_valid  = v;
        mem_wb_aluout1    = a1;
        mem_wb_aluout2    = a2;
        id_rs1            = r1;
        id_rs2            = r2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_trace(input string tag, input logic v, input logic we,
                               input logic [4:0] rd, input logic [31:0] data);
        check({tag, ".valid"}, 64'(wb_commit_valid), 64'(v));
        check({tag, ".we"},    64'(wb_commit_we),    64'(we));
        check({tag, ".rd"},    64'(wb_commit_rd),    64'(rd));
        check({tag, ".data"},  64'(wb_commit_data),  64'(data));
    endtask

    initial begin
        rst = 1'b0;
        mem_wb_rd = '0; mem_wb_mem_to_reg = 1'b0; mem_wb_regwrite = 1'b0;
        mem_wb_ins_valid = 1'b0; mem_wb_aluout1 = '0; mem_wb_aluout2 = '0;
        id_rs1 = 5'd5; id_rs2 = 5'd7;
        #1;
        check("rst.rs1", 64'(rs1_data), 64'h0);
        check("rst.instret", instret, 64'h0);
        check("rst.commit_valid", 64'(wb_commit_valid), 64'h0);

        @(negedge clk);
        rst = 1'b1;

        // ALU write to x5: bypass same cycle, array next cycle
        drive(5'd5, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0, 5'd5, 5'd0);
        check("wr.bypass.rs1", 64'(rs1_data), 64'hDEADBEEF);
        check("wr.bypass.rs2_x0", 64'(rs2_data), 64'h0);
        tick();
        check_trace("wr.trace", 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        check("wr.instret", instret, 64'd1);
        drive(5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5);
        check("wr.array.rs1", 64'(rs1_data), 64'hDEADBEEF);
        check("wr.array.rs2", 64'(rs2_data), 64'hDEADBEEF);

        // Load select into x7
        drive(5'd7, 1'b1, 1'b1, 1'b1, 32'h1, 32'h12345678, 5'd7, 5'd0);
        check("ld.bypass", 64'(rs1_data), 64'h12345678);
        tick();
        check("ld.trace.data", 64'(wb_commit_data), 64'h12345678);
        check("ld.instret", instret, 64'd2);
        drive(5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd0);
        check("ld.array", 64'(rs1_data), 64'h12345678);

        // Write to x0 is dropped but still retires
        drive(5'd0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0);
        check("x0.rs1", 64'(rs1_data), 64'h0);
        check("x0.rs2", 64'(rs2_data), 64'h0);
        tick();
        check_trace("x0.trace", 1'b1, 1'b0, 5'd0, 32'h0);
        check("x0.instret", instret, 64'd3);

        // Bubble with regwrite set: no bypass, no write, no count
        drive(5'd5, 1'b0, 1'b1, 1'b0, 32'h11111111, 32'h0, 5'd5, 5'd0);
        check("bub.nobypass", 64'(rs1_data), 64'hDEADBEEF);
        tick();
        check_trace("bub.trace", 1'b0, 1'b0, 5'd0, 32'h0);
        check("bub.instret", instret, 64'd3);
        drive(5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd0);
        check("bub.array", 64'(rs1_data), 64'hDEADBEEF);

        // Dual bypass on x9, then second port on untouched x10
        drive(5'd10, 1'b0, 1'b1, 1'b1, 32'h0BADF00D, 32'h0, 5'd0, 5'd0);
        tick();
        drive(5'd9, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h0, 5'd9, 5'd9);
        check("dual.rs1", 64'(rs1_data), 64'hA5A5A5A5);
        check("dual.rs2", 64'(rs2_data), 64'hA5A5A5A5);
        id_rs2 = 5'd10;
        #1;
        check("dual.rs2_old", 64'(rs2_data), 64'h0BADF00D);
        tick();
        check("dual.instret", instret, 64'd5);

        // Back-to-back writes to x3: later wins, both traced and counted
        drive(5'd3, 1'b0, 1'b1, 1'b1, 32'h00000001, 32'h0, 5'd3, 5'd0);
        tick();
        check_trace("b2b.first", 1'b1, 1'b1, 5'd3, 32'h1);
        drive(5'd3, 1'b1, 1'b1, 1'b1, 32'h0, 32'h00000002, 5'd3, 5'd0);
        check("b2b.bypass", 64'(rs1_data), 64'h2);
        tick();
        check_trace("b2b.second", 1'b1, 1'b1, 5'd3, 32'h2);
        check("b2b.instret", instret, 64'd7);
        check("narrow.instret", 64'(n_instret), 64'd3);

        // Mid-stream asynchronous reset drops the in-flight write to x12
        drive(5'd12, 1'b0, 1'b1, 1'b1, 32'h00000077, 32'h0, 5'd5, 5'd12);
        check("pre_rst.bypass", 64'(rs2_data), 64'h77);
        #1;
        rst = 1'b0;
        #1;
        check("mrst.rs1", 64'(rs1_data), 64'h0);
        check("mrst.rs2", 64'(rs2_data), 64'h0);
        check("mrst.instret", instret, 64'h0);
        check("mrst.commit_valid", 64'(wb_commit_valid), 64'h0);
        tick();
        drive(5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd12);
        rst = 1'b1;
        #1;
        check("post_rst.x5", 64'(rs1_data), 64'h0);
        check("post_rst.x12", 64'(rs2_data), 64'h0);
        tick();
        check("post_rst.instret", instret, 64'h0);

        // Counter wrap on the 2-bit instance: 3 -> 0
        for (int i = 0; i < 3; i++) begin
            drive(5'd1, 1'b0, 1'b1, 1'b1, 32'(i), 32'h0, 5'd0, 5'd0);
            tick();
        end
        check("wrap.before", 64'(n_instret), 64'd3);
        drive(5'd1, 1'b0, 1'b1, 1'b1, 32'h3, 32'h0, 5'd1, 5'd0);
        tick();
        check("wrap.after", 64'(n_instret), 64'd0);
        check("wrap.wide_instret", instret, 64'd4);
        drive(5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd1, 5'd0);
        check("wrap.x1", 64'(rs1_data), 64'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
